// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers for the
// Execute stage. mult/multu/div/divu run as multi-cycle operations; the result
// is computed at the start cycle, parked in res_hi/res_lo and committed to
// HI/LO when the down-counter reaches zero. mfhi/mflo read HI/LO
// combinationally and mthi/mtlo write them in a single cycle.
//
// Optional feature macro: MDU_MADD_EN adds madd (op 9) and maddu (op 10),
// which accumulate a signed/unsigned product into {HI,LO}. When the macro is
// undefined those codes decode as "none".
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [3:0] MULT_LEN = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LEN  = 4'(DIV_CYCLES);

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    logic        is_mul;
    logic        is_div;
    logic        is_mac;
    logic        is_mthi;
    logic        is_mtlo;
    logic        is_multi;
    logic        idle;
    logic        go;
    logic        mt_go;
    logic [3:0]  op_len;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b_s;
    logic        [31:0] div_b_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_wr;

    // Opcode decode into operation classes
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mac  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: is_mul  = 1'b1;
            OP_DIV, OP_DIVU:   is_div  = 1'b1;
            OP_MTHI:           is_mthi = 1'b1;
            OP_MTLO:           is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: is_mac  = 1'b1;
`endif
            default: ;
        endcase
    end

    assign is_multi = is_mul | is_div | is_mac;
    assign idle     = (cnt == 4'd0);
    assign go       = start & ~req & is_multi & idle;
    assign mt_go    = start & ~req & (is_mthi | is_mtlo) & idle;
    assign op_len   = is_div ? DIV_LEN : MULT_LEN;

    // Stall request: a starting multi-cycle op or one still counting down
    assign busy = (start & ~req & is_multi) | ~idle;

    // Products and quotients. The signed divisor is forced to 1 both for
    // divide-by-zero (result discarded anyway) and for INT_MIN / -1, where
    // dividing by 1 yields exactly the architected answer (LO=INT_MIN, HI=0)
    // without relying on overflowing signed division.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        div_b_s = ((B == 32'd0) || (A == INT_MIN && B == NEG_ONE)) ? 32'd1 : B;
        div_b_u = (B == 32'd0) ? 32'd1 : B;
        quot_s  = $signed(A) / $signed(div_b_s);
        rem_s   = $signed(A) % $signed(div_b_s);
        quot_u  = A / div_b_u;
        rem_u   = A % div_b_u;
    end

    // Select the pending HI/LO result and whether it will be committed
    always_comb begin
        calc_hi = hi;
        calc_lo = lo;
        calc_wr = 1'b0;
        case (op)
            OP_MULT: begin
                {calc_hi, calc_lo} = prod_s;
                calc_wr = 1'b1;
            end
            OP_MULTU: begin
                {calc_hi, calc_lo} = prod_u;
                calc_wr = 1'b1;
            end
            OP_DIV: begin
                calc_lo = quot_s;
                calc_hi = rem_s;
                calc_wr = (B != 32'd0);
            end
            OP_DIVU: begin
                calc_lo = quot_u;
                calc_hi = rem_u;
                calc_wr = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {calc_hi, calc_lo} = {hi, lo} + prod_s;
                calc_wr = 1'b1;
            end
            OP_MADDU: begin
                {calc_hi, calc_lo} = {hi, lo} + prod_u;
                calc_wr = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Read port for mfhi/mflo
    always_comb begin
        out = 32'd0;
        case (op)
            OP_MFHI: out = hi;
            OP_MFLO: out = lo;
            default: ;
        endcase
    end

    // Countdown, pending-result capture, commit and mt writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else if (!idle) begin
            // req is deliberately ignored here: the op in flight is older
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (go) begin
            res_hi <= calc_hi;
            res_lo <= calc_lo;
            res_wr <= calc_wr;
            cnt    <= op_len;
            // A zero-length configuration commits on the start edge itself
            if (op_len == 4'd0 && calc_wr) begin
                hi <= calc_hi;
                lo <= calc_lo;
            end
        end else if (mt_go) begin
            if (is_mthi) hi <= A;
            if (is_mtlo) lo <= A;
        end
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit with architectural HI/LO registers for the Execute stage of the five-stage MIPS pipeline. It runs mult/multu/div/divu as multi-cycle operations and services mfhi/mflo/mthi/mtlo. Its `busy` output is the HILO-busy input consumed by the D-stage stall logic: it holds HILO-class instructions in Decode until the result has committed. `req` comes from the CP0/exception path and suppresses any architectural write from the instruction currently in E.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd/maddu after the start cycle.
- `DIV_CYCLES`, default 10: busy cycles for div/divu after the start cycle.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state.
- `req` input 1: exception/interrupt flush of the E-stage instruction. Blocks `start` and mt writes in the same cycle.
- `start` input 1: E-stage instruction is a mult/div-class op. Meaningful only together with `op`.
- `op` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu. Codes 9-10 exist only under the macro. Other codes are treated as none.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `busy` output 1: `(start & ~req & op∈{1,2,3,4,9,10})` OR an operation in flight. Combinational.
- `out` output 32: HI when op=5, LO when op=6, otherwise 0. Combinational from the registers.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- State: `hi`, `lo`, `cnt` (4 bits), pending result registers `res_hi` and `res_lo`.
- Idle means `cnt == 0`.
- On a valid start (`start & ~req & idle` with a multi-cycle op):
  - compute the result into `res_hi`/`res_lo`;
  - load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
- Each cycle with `cnt != 0`, `cnt` decrements.
- When `cnt` goes 1→0, `res_hi`/`res_lo` are committed to `hi`/`lo` on that edge.
- Arithmetic:
  - mult: signed 32×32→64, HI = upper 32 bits, LO = lower 32 bits.
  - multu: the same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: the same, unsigned.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
  - Divide by zero: the operation still runs the full `DIV_CYCLES` and still asserts `busy`, but HI/LO are left unchanged.
- mthi/mtlo (`~req`): write `A` to HI/LO on the edge. Single cycle; `busy` is not asserted.
- A start arriving while not idle is ignored; the stall unit guarantees this never happens. Likewise an mt while not idle is ignored.
- `req` never aborts an in-flight operation, because the in-flight operation belongs to an older, committed instruction.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `cnt` = 0, `busy` = 0, `out` = 0.
- Start in cycle T:
  - `busy` = 1 in T (combinational) and in T+1 .. T+N.
  - New HI/LO are visible from T+N+1.
  - `busy` = 0 from T+N+1.
- mfhi/mflo read the current registers combinationally. Stall guarantees no mf issues while `busy` is high.
- mt written in cycle T is visible on `hi`/`lo`/`out` from T+1.
- Reset asserted mid-operation: `cnt`, `hi`, `lo` and the pending result clear immediately; the result is never committed.
- `start` and `req` in the same cycle: no start, `busy` = 0, `cnt` unchanged.

## Configuration
- `MDU_MADD_EN` defined:
  - op 9 (madd) computes `{hi,lo} + signed(A)×signed(B)` (64-bit wrap).
  - op 10 (maddu) computes the unsigned equivalent.
  - Both take `MULT_CYCLES` and sample the HI/LO values present at the start cycle.
- Undefined: ops 9 and 10 decode as none. No start, `busy` = 0, no write.

## Test plan
- Reset then idle: `hi` = `lo` = `out` = 0 and `busy` = 0 throughout.
- mult, A=0xFFFFFFFE (-2), B=3, start at T:
  - `busy` high T..T+5;
  - at T+6, HI = 0xFFFFFFFF and LO = 0xFFFFFFFA;
  - multu with the same operands gives HI = 0x00000002, LO = 0xFFFFFFFA.
- div, A=-7, B=2: after 11 cycles LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). div with B=0: `busy` for 11 cycles and HI/LO are unchanged.
- mthi with A=0x12345678 and `req`=0, then mfhi: `out` = 0x12345678 next cycle. The same mthi with `req`=1: HI unchanged.
- start+`req` together: `busy` = 0 and no commit. `reset` pulsed at T+3 of a div: HI/LO = 0 and `busy` drops immediately.
- Under `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then maddu with A=1, B=1 gives HI = 1, LO = 0 after 6 cycles.
